rr_mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one 4:1 data mux among four requesters.
- Grants one requester at a time and drives the mux select pair (s1 = sel[1], s2 = sel[0]).
- Captures the selected requester's data into a registered output, one beat per cycle.
- Limits each grant to MAX_BURST beats so all requesters get fair access to the shared output path.

---
 rtl/rr_mux_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_mux_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//
// Round-robin arbiter and sequencer that shares one 4:1 data mux among
// four requesters. One requester is granted at a time. The selected
// requester's data is captured into a registered output at one beat per
// cycle. Each grant is capped at MAX_BURST beats so that every requester
// gets fair access to the shared output path.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req[3:0]   per-requester request, held high while requester k has data
//   din0..din3 requester data, DW bits each
//   gnt[3:0]   registered one-hot grant, all zeros when idle
//   sel[1:0]   mux select = index of current/last owner (sel[1]=s1, sel[0]=s2)
//   dout       registered muxed data
//   dout_valid dout holds a beat captured on the previous edge
//   busy       high while a grant is active (equals |gnt)

module rr_mux_arbiter #(
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [3:0]    req,
    input  logic [DW-1:0] din0,
    input  logic [DW-1:0] din1,
    input  logic [DW-1:0] din2,
    input  logic [DW-1:0] din3,
    output logic [3:0]    gnt,
    output logic [1:0]    sel,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [CW-1:0] cnt;

    // Returns {found, index}. Scanning from the far end downwards lets the
    // requester closest to 'start' overwrite later candidates, so it wins.
    function automatic logic [2:0] arbitrate(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [2:0]    idle_win;
    logic [2:0]    rel_win;
    logic [1:0]    next_start;
    logic [CW-1:0] cnt_next;
    logic [DW-1:0] mux_data;

    // While granted, sel is the owner index, so it drives both the data mux
    // and the release scan (owner gets lowest priority on release).
    always_comb begin
        next_start = sel + 2'd1;
        idle_win   = arbitrate(req, ptr);
        rel_win    = arbitrate(req, next_start);
        cnt_next   = cnt + 1'b1;
        mux_data   = din0;
        case (sel)
            2'd0:    mux_data = din0;
            2'd1:    mux_data = din1;
            2'd2:    mux_data = din2;
            default: mux_data = din3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= 4'b0000;
            sel        <= 2'd0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            ptr        <= 2'd0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dout_valid <= 1'b0;
                    if (idle_win[2]) begin
                        gnt   <= 4'b0001 << idle_win[1:0];
                        sel   <= idle_win[1:0];
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= GRANT;
                    end
                end

                default: begin
                    if (req[sel]) begin
                        dout       <= mux_data;
                        dout_valid <= 1'b1;
                        cnt        <= cnt_next;
                    end else begin
                        dout_valid <= 1'b0;
                    end

                    // Release on a dropped request or a completed burst; the
                    // handover happens on this same edge with no idle bubble.
                    if (!req[sel] || cnt_next == BURST_LAST) begin
                        ptr <= next_start;
                        cnt <= '0;
                        if (rel_win[2]) begin
                            gnt <= 4'b0001 << rel_win[1:0];
                            sel <= rel_win[1:0];
                        end else begin
                            gnt   <= 4'b0000;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed testbench for rr_mux_arbiter (DW=8, MAX_BURST=4).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. they reflect the state loaded on that edge.

module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] din0, din1, din2, din3;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [7:0] dout;
    logic       dout_valid;
    logic       busy;

    int n_cmp;
    int n_bad;

    rr_mux_arbiter #(.DW(8), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'hF;
        din0  = 8'hFF; din1 = 8'hFF; din2 = 8'hFF; din3 = 8'hFF;
        step();
        step();
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got %h want 0", gnt); end
        n_cmp++; if (sel !== 2'b00) begin n_bad++; $display("FAIL reset_sel got %h want 0", sel); end
        n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_dout got %h want 00", dout); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", dout_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        rst_n = 1'b1;
        step();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL reset_release_gnt got %b want 0001", gnt); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release_valid got %b want 0", dout_valid); end
    endtask

    task automatic test_single();
        do_reset();
        req  = 4'b0100;
        din2 = 8'hA5;
        step();
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_gnt got %b want 0100", gnt); end
        n_cmp++; if (sel !== 2'b10) begin n_bad++; $display("FAIL single_sel got %b want 10", sel); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL single_first_valid got %b want 0", dout_valid); end
        for (int b = 0; b < 3; b++) begin
            step();
            n_cmp++; if (dout !== 8'hA5 || dout_valid !== 1'b1)
                begin n_bad++; $display("FAIL single_beat%0d got %h/%b want a5/1", b, dout, dout_valid); end
            n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL single_hold%0d got %b want 0100", b, gnt); end
        end
        req = 4'b0000;
        step();
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_drop_gnt got %b want 0000", gnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_drop_busy got %b want 0", busy); end
        n_cmp++; if (dout_valid !== 1'b0) begin n_bad++; $display("FAIL single_drop_valid got %b want 0", dout_valid); end
        n_cmp++; if (dut.ptr !== 2'd3) begin n_bad++; $display("FAIL single_drop_ptr got %0d want 3", dut.ptr); end
        n_cmp++; if (dout !== 8'hA5) begin n_bad++; $display("FAIL single_drop_dout got %h want a5", dout); end
        n_cmp++; if (sel !== 2'b10) begin n_bad++; $display("FAIL single_drop_sel got %b want 10", sel); end
    endtask

    task automatic test_contention();
        logic [3:0] exp_gnt;
        logic [7:0] exp_dout;
        do_reset();
        din0 = 8'h10; din1 = 8'h11; din2 = 8'h12; din3 = 8'h13;
        req  = 4'hF;
        step();
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL cont_first_gnt got %b want 0001", gnt); end
        for (int o = 0; o < 5; o++) begin
            for (int b = 0; b < 4; b++) begin
                step();
                exp_dout = 8'h10 + 8'(o % 4);
                exp_gnt  = (b == 3) ? (4'b0001 << ((o + 1) % 4)) : (4'b0001 << (o % 4));
                n_cmp++; if (dout !== exp_dout || dout_valid !== 1'b1)
                    begin n_bad++; $display("FAIL cont_dout o%0d b%0d got %h/%b want %h/1", o, b, dout, dout_valid, exp_dout); end
                n_cmp++; if (gnt !== exp_gnt)
                    begin n_bad++; $display("FAIL cont_gnt o%0d b%0d got %b want %b", o, b, gnt, exp_gnt); end
            end
        end
        req = 4'b0000;
        step();
    endtask

    task automatic test_fairness();
        do_reset();
        din0 = 8'h20; din1 = 8'h21; din2 = 8'h22; din3 = 8'h23;
        req  = 4'b0010;
        step();
        n_cmp++; if (sel !== 2'b01) begin n_bad++; $display("FAIL fair_sel1 got %b want 01", sel); end
        req = 4'b1011;
        for (int b = 0; b < 4; b++) begin
            step();
            n_cmp++; if (dout !== 8'h21) begin n_bad++; $display("FAIL fair_dout1 b%0d got %h want 21", b, dout); end
            n_cmp++; if (sel !== ((b == 3) ? 2'b11 : 2'b01))
                begin n_bad++; $display("FAIL fair_sel_a b%0d got %b want %b", b, sel, (b == 3) ? 2'b11 : 2'b01); end
        end
        for (int b = 0; b < 4; b++) begin
            step();
            n_cmp++; if (dout !== 8'h23) begin n_bad++; $display("FAIL fair_dout3 b%0d got %h want 23", b, dout); end
            n_cmp++; if (sel !== ((b == 3) ? 2'b00 : 2'b11))
                begin n_bad++; $display("FAIL fair_sel_b b%0d got %b want %b", b, sel, (b == 3) ? 2'b00 : 2'b11); end
        end
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL fair_gnt0 got %b want 0001", gnt); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_sole();
        do_reset();
        din0 = 8'h5A;
        req  = 4'b0001;
        step();
        for (int b = 1; b <= 10; b++) begin
            step();
            n_cmp++; if (gnt !== 4'b0001 || dout_valid !== 1'b1 || dout !== 8'h5A)
                begin n_bad++; $display("FAIL sole_beat%0d got %b/%b/%h want 0001/1/5a", b, gnt, dout_valid, dout); end
            n_cmp++; if (dut.cnt !== 3'(b % 4))
                begin n_bad++; $display("FAIL sole_cnt%0d got %0d want %0d", b, dut.cnt, b % 4); end
        end
        req = 4'b0000;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL sole_end_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        din0 = 8'h30; din3 = 8'h33;
        req  = 4'b1000;
        step();
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL mid_gnt3 got %b want 1000", gnt); end
        step();
        n_cmp++; if (dout !== 8'h33) begin n_bad++; $display("FAIL mid_beat1 got %h want 33", dout); end
        rst_n = 1'b0;
        step();
        n_cmp++; if (gnt !== 4'b0000 || sel !== 2'b00 || busy !== 1'b0)
            begin n_bad++; $display("FAIL mid_rst_ctrl got %b/%b/%b want 0000/00/0", gnt, sel, busy); end
        n_cmp++; if (dout !== 8'h00 || dout_valid !== 1'b0)
            begin n_bad++; $display("FAIL mid_rst_data got %h/%b want 00/0", dout, dout_valid); end
        n_cmp++; if (dut.ptr !== 2'd0) begin n_bad++; $display("FAIL mid_rst_ptr got %0d want 0", dut.ptr); end
        rst_n = 1'b1;
        req   = 4'b1001;
        step();
        n_cmp++; if (gnt !== 4'b0001 || sel !== 2'b00)
            begin n_bad++; $display("FAIL mid_regrant got %b/%b want 0001/00", gnt, sel); end
        step();
        n_cmp++; if (dout !== 8'h30 || dout_valid !== 1'b1)
            begin n_bad++; $display("FAIL mid_first_beat got %h/%b want 30/1", dout, dout_valid); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        din0  = 8'h00; din1 = 8'h00; din2 = 8'h00; din3 = 8'h00;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_sole();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
